// File: rtl/wb_regfile_pkg.sv
// Shared types and opcode constants for the write-back stage.
// Build option: define RF_BYPASS_EN for same-cycle write-through reads.
package pipe_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      reg_idx_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BUBBLE = 7'h00;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: pipeline inputs, decode read ports and
// the write-back/forwarding outputs. The slave side is the register file.
interface wb_regfile_if #(
    parameter int CNT_W = 64
);
    import pipe_pkg::*;

    word_t            result_in;
    word_t            read_data_in;
    logic             mem_to_reg_in;
    reg_idx_t         rd_in;
    logic             reg_write_in;
    word_t            imm_in;
    logic [6:0]       op_in;
    logic             U_type_in;
    reg_idx_t         rs1_addr;
    reg_idx_t         rs2_addr;
    word_t            rs1_data;
    word_t            rs2_data;
    word_t            wb_data;
    logic             wb_we;
    reg_idx_t         wb_rd;
    word_t            prev_wb_data;
    reg_idx_t         prev_wb_rd;
    logic [CNT_W-1:0] instret;

    modport master (
        output result_in, read_data_in, mem_to_reg_in, rd_in, reg_write_in,
               imm_in, op_in, U_type_in, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_we, wb_rd,
               prev_wb_data, prev_wb_rd, instret
    );

    modport slave (
        input  result_in, read_data_in, mem_to_reg_in, rd_in, reg_write_in,
               imm_in, op_in, U_type_in, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_we, wb_rd,
               prev_wb_data, prev_wb_rd, instret
    );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Write-back value select: LUI immediate, then load data, then ALU result.
// AUIPC needs no special case since its sum already arrives as the ALU result.
module wb_mux
    import pipe_pkg::*;
(
    input  word_t      result_i,
    input  word_t      read_data_i,
    input  word_t      imm_i,
    input  logic       mem_to_reg_i,
    input  logic       u_type_i,
    input  logic [6:0] op_i,
    output word_t      wb_data_o
);

    // Priority select of the value to commit
    always_comb begin
        wb_data_o = result_i;
        if (u_type_i && (op_i == OP_LUI)) begin
            wb_data_o = imm_i;
        end else if (mem_to_reg_i) begin
            wb_data_o = read_data_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: 32x32 register file with two combinational read ports,
// one-cycle write-back history for forwarding, and retired-instruction count.
// Build option: RF_BYPASS_EN makes a read of the register being written
// return the new value in the same cycle; otherwise it returns the old value.
module wb_regfile
    import pipe_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    wb_regfile_if.slave bus
);

    word_t            wb_data_w;
    logic             wb_we_w;
    word_t            rs1_w;
    word_t            rs2_w;
    word_t            regs_q [NREGS];
    word_t            prev_wb_data_q, prev_wb_data_d;
    reg_idx_t         prev_wb_rd_q, prev_wb_rd_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    wb_mux u_wb_mux (
        .result_i     (bus.result_in),
        .read_data_i  (bus.read_data_in),
        .imm_i        (bus.imm_in),
        .mem_to_reg_i (bus.mem_to_reg_in),
        .u_type_i     (bus.U_type_in),
        .op_i         (bus.op_in),
        .wb_data_o    (wb_data_w)
    );

    // Bubbles and x0 targets never commit, whatever reg_write_in says
    assign wb_we_w = bus.reg_write_in && (bus.rd_in != '0) && (bus.op_in != OP_BUBBLE);

    // Register array commit; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we_w) begin
            regs_q[bus.rd_in] <= wb_data_w;
        end
    end

    // Combinational read ports with optional write-through bypass
    always_comb begin
        rs1_w = '0;
        rs2_w = '0;
        if (bus.rs1_addr != '0) rs1_w = regs_q[bus.rs1_addr];
        if (bus.rs2_addr != '0) rs2_w = regs_q[bus.rs2_addr];
`ifdef RF_BYPASS_EN
        // wb_we_w already implies rd_in != 0, so x0 reads are never bypassed
        if (wb_we_w && (bus.rs1_addr == bus.rd_in)) rs1_w = wb_data_w;
        if (wb_we_w && (bus.rs2_addr == bus.rd_in)) rs2_w = wb_data_w;
`endif
    end

    // Next state of the forwarding history and the retire counter
    always_comb begin
        prev_wb_data_d = prev_wb_data_q;
        prev_wb_rd_d   = '0;
        instret_d      = instret_q;
        if (wb_we_w) begin
            prev_wb_data_d = wb_data_w;
            prev_wb_rd_d   = bus.rd_in;
        end
        if (bus.op_in != OP_BUBBLE) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // History and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_wb_data_q <= '0;
            prev_wb_rd_q   <= '0;
            instret_q      <= '0;
        end else begin
            prev_wb_data_q <= prev_wb_data_d;
            prev_wb_rd_q   <= prev_wb_rd_d;
            instret_q      <= instret_d;
        end
    end

    assign bus.rs1_data     = rs1_w;
    assign bus.rs2_data     = rs2_w;
    assign bus.wb_data      = wb_data_w;
    assign bus.wb_we        = wb_we_w;
    assign bus.wb_rd        = bus.rd_in;
    assign bus.prev_wb_data = prev_wb_data_q;
    assign bus.prev_wb_rd   = prev_wb_rd_q;
    assign bus.instret      = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic checked
// against an array-based model of the architectural register state.
module tb_wb_regfile;
    import pipe_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Architectural model
    logic [31:0] m_regs [32];
    logic [31:0] m_prev_data;
    logic [4:0]  m_prev_rd;
    logic [63:0] m_instret;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_prev_data = '0;
        m_prev_rd   = '0;
        m_instret   = '0;
    endfunction

    function automatic logic [31:0] exp_wb();
        if (bus.U_type_in && bus.op_in == OP_LUI) return bus.imm_in;
        if (bus.mem_to_reg_in) return bus.read_data_in;
        return bus.result_in;
    endfunction

    function automatic logic exp_we();
        return bus.reg_write_in && bus.rd_in != 0 && bus.op_in != OP_BUBBLE;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && exp_we() && a == bus.rd_in) return exp_wb();
        return m_regs[a];
    endfunction

    task automatic set_in(input logic [6:0] op, input logic u, input logic mem,
                          input logic rw, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] rdat,
                          input logic [31:0] imm);
        bus.op_in = op; bus.U_type_in = u; bus.mem_to_reg_in = mem;
        bus.reg_write_in = rw; bus.rd_in = rd; bus.result_in = res;
        bus.read_data_in = rdat; bus.imm_in = imm;
    endtask

    // Advance one clock and apply the architectural effect of the current inputs
    task automatic tick();
        logic [31:0] w;
        logic        we;
        w  = exp_wb();
        we = exp_we();
        @(posedge clk);
        if (rst) begin
            if (we) begin
                m_regs[bus.rd_in] = w;
                m_prev_data = w;
                m_prev_rd   = bus.rd_in;
            end else begin
                m_prev_rd = '0;
            end
            if (bus.op_in != OP_BUBBLE) m_instret = m_instret + 64'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        bus.rs1_addr = 5; bus.rs2_addr = 5;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        checks++;
        if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1 got %h exp 0", bus.rs1_data); end
        checks++;
        if (bus.instret !== 64'h0) begin errors++; $display("FAIL reset_instret got %0d exp 0", bus.instret); end
        checks++;
        if (bus.prev_wb_rd !== 5'd0 || bus.prev_wb_data !== 32'h0) begin
            errors++; $display("FAIL reset_prev got rd=%0d data=%h exp 0/0", bus.prev_wb_rd, bus.prev_wb_data);
        end
    endtask

    task automatic test_lui();
        set_in(OP_LUI, 1, 0, 1, 3, 32'h0000_0099, 32'h0000_0077, 32'h12345000);
        bus.rs1_addr = 3;
        #2;
        checks++;
        if (bus.wb_data !== 32'h12345000 || bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd3) begin
            errors++; $display("FAIL lui_wb got %h we=%b rd=%0d exp 12345000 1 3", bus.wb_data, bus.wb_we, bus.wb_rd);
        end
        tick();
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (bus.rs1_data !== 32'h12345000) begin errors++; $display("FAIL lui_x3 got %h exp 12345000", bus.rs1_data); end
        checks++;
        if (bus.prev_wb_rd !== 5'd3 || bus.prev_wb_data !== 32'h12345000) begin
            errors++; $display("FAIL lui_prev got rd=%0d data=%h exp 3/12345000", bus.prev_wb_rd, bus.prev_wb_data);
        end
        tick();
    endtask

    task automatic test_load();
        set_in(OP_LOAD, 0, 1, 1, 7, 32'h4, 32'hDEADBEEF, 32'h4);
        #2;
        checks++;
        if (bus.wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_wb got %h exp deadbeef", bus.wb_data); end
        tick();
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        bus.rs2_addr = 7;
        #2;
        checks++;
        if (bus.rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_x7 got %h exp deadbeef", bus.rs2_data); end
        // bubble cycle: history must clear its destination
        tick();
        checks++;
        if (bus.prev_wb_rd !== 5'd0 || bus.prev_wb_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bubble_prev got rd=%0d data=%h exp 0/deadbeef", bus.prev_wb_rd, bus.prev_wb_data);
        end
    endtask

    task automatic test_x0();
        set_in(OP_ALU, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        bus.rs1_addr = 0;
        #2;
        checks++;
        if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b exp 0", bus.wb_we); end
        checks++;
        if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL x0_same got %h exp 0", bus.rs1_data); end
        tick();
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.prev_wb_rd !== 5'd0) begin
            errors++; $display("FAIL x0_after got %h rd=%0d exp 0/0", bus.rs1_data, bus.prev_wb_rd);
        end
    endtask

    task automatic test_same_cycle();
        set_in(OP_ALU, 0, 0, 1, 9, 32'h1, 0, 0);
        tick();
        set_in(OP_ALU, 0, 0, 1, 9, 32'hAA, 0, 0);
        bus.rs1_addr = 9; bus.rs2_addr = 9;
        #2;
        checks++;
        if (bus.rs2_data !== (BYP ? 32'hAA : 32'h1)) begin
            errors++; $display("FAIL rw_same got %h exp %h", bus.rs2_data, (BYP ? 32'hAA : 32'h1));
        end
        checks++;
        if (bus.rs1_data !== bus.rs2_data || bus.rs1_data !== exp_rd(9)) begin
            errors++; $display("FAIL rw_ports rs1=%h rs2=%h exp %h", bus.rs1_data, bus.rs2_data, exp_rd(9));
        end
        tick();
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (bus.rs2_data !== 32'hAA) begin errors++; $display("FAIL rw_next got %h exp aa", bus.rs2_data); end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = OP_BUBBLE; ops[1] = OP_LUI; ops[2] = OP_AUIPC;
        ops[3] = OP_LOAD;   ops[4] = OP_ALU; ops[5] = OP_STORE;
        for (int n = 0; n < 300; n++) begin
            op = ops[$urandom_range(0, 5)];
            set_in(op, ($urandom_range(0, 3) != 0) ? (op == OP_LUI || op == OP_AUIPC) : 1'($urandom),
                   (op == OP_LOAD) ? 1'b1 : 1'($urandom_range(0, 7) == 0),
                   1'($urandom), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom & 32'hFFFFF000);
            bus.rs1_addr = ($urandom_range(0, 3) == 0) ? bus.rd_in : 5'($urandom);
            bus.rs2_addr = ($urandom_range(0, 3) == 0) ? bus.rd_in : 5'($urandom);
            #2;
            checks++;
            if (bus.wb_data !== exp_wb() || bus.wb_we !== exp_we()) begin
                errors++; $display("FAIL rnd_wb n=%0d got %h/%b exp %h/%b", n, bus.wb_data, bus.wb_we, exp_wb(), exp_we());
            end
            checks++;
            if (bus.rs1_data !== exp_rd(bus.rs1_addr) || bus.rs2_data !== exp_rd(bus.rs2_addr)) begin
                errors++; $display("FAIL rnd_rd n=%0d got %h/%h exp %h/%h", n, bus.rs1_data, bus.rs2_data,
                                   exp_rd(bus.rs1_addr), exp_rd(bus.rs2_addr));
            end
            tick();
            checks++;
            if (bus.prev_wb_data !== m_prev_data || bus.prev_wb_rd !== m_prev_rd || bus.instret !== m_instret) begin
                errors++; $display("FAIL rnd_hist n=%0d got %h/%0d/%0d exp %h/%0d/%0d", n, bus.prev_wb_data,
                                   bus.prev_wb_rd, bus.instret, m_prev_data, m_prev_rd, m_instret);
            end
        end
    endtask

    task automatic test_counter();
        rst = 1'b0;
        model_reset();
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in((i % 2) ? OP_STORE : OP_ALU, 0, 0, 1'(i % 2 == 0), 5'(i + 10), 32'(i), 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(OP_BUBBLE, 0, 0, 1, 4, 32'h5A5A5A5A, 0, 0);
            tick();
        end
        bus.rs1_addr = 4;
        #2;
        checks++;
        if (bus.instret !== 64'd10) begin errors++; $display("FAIL cnt_instret got %0d exp 10", bus.instret); end
        checks++;
        if (bus.rs1_data !== 32'h0) begin errors++; $display("FAIL cnt_bubble_wr got %h exp 0", bus.rs1_data); end
    endtask

    task automatic test_reset_mid();
        set_in(OP_ALU, 0, 0, 1, 12, 32'h77, 0, 0);
        tick();
        set_in(OP_ALU, 0, 0, 1, 12, 32'h55, 0, 0);
        bus.rs1_addr = 12;
        #2;
        checks++;
        if (bus.rs1_data !== m_regs[12]) begin errors++; $display("FAIL mid_pre got %h exp %h", bus.rs1_data, m_regs[12]); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.instret !== 64'h0 || bus.prev_wb_rd !== 5'd0 || bus.prev_wb_data !== 32'h0) begin
            errors++; $display("FAIL mid_async got %h/%0d/%0d/%h exp all 0", bus.rs1_data, bus.instret,
                               bus.prev_wb_rd, bus.prev_wb_data);
        end
        @(posedge clk); #1 rst = 1'b1;
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (bus.rs1_data !== 32'h0 || bus.instret !== 64'h0) begin
            errors++; $display("FAIL mid_lost got %h/%0d exp 0/0", bus.rs1_data, bus.instret);
        end
    endtask

    initial begin
        bus.rs1_addr = 0;
        bus.rs2_addr = 0;
        set_in(OP_BUBBLE, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_lui();
        test_load();
        test_x0();
        test_same_cycle();
        test_random();
        test_counter();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
